// File: rtl/bm_arb_pkg.sv
// bm_arb_pkg: shared types and helpers for the BondMachine output arbiter.
// Optional downstream timeout is enabled with the BM_ARB_TIMEOUT_EN macro
// (see bm_output_arbiter).
package bm_arb_pkg;

   // Arbiter FSM: IDLE has no captured word, SEND presents one downstream.
   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } bm_arb_state_e;

   // Next round-robin index after idx, wrapping at n-1 back to 0.
   function automatic int unsigned rr_index_next(input int unsigned idx,
                                                 input int unsigned n);
      if (idx + 1 >= n) begin
         return 0;
      end
      return idx + 1;
   endfunction

endpackage

// File: rtl/bm_rr_picker.sv
// bm_rr_picker: combinational round-robin winner search.
// Scans req starting at ptr, ascending, wrapping at NUM_SRC-1 to 0; the
// first set bit wins. Used by bm_output_arbiter (BM_ARB_TIMEOUT_EN has no
// effect here).
module bm_rr_picker
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = $clog2(NUM_SRC)
)(
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic               any,
   output logic [SRC_W-1:0]   winner,
   output logic [NUM_SRC-1:0] onehot
);

   // One extra bit so ptr + k never overflows before the wrap subtraction.
   logic [SRC_W:0]   sum;
   logic [SRC_W-1:0] idx;

   // Priority search from ptr with wrap-around; first hit wins.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      onehot = '0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         sum = {1'b0, ptr} + (SRC_W+1)'(k);
         if (sum >= (SRC_W+1)'(NUM_SRC)) begin
            sum = sum - (SRC_W+1)'(NUM_SRC);
         end
         idx = sum[SRC_W-1:0];
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
      if (any) begin
         onehot[winner] = 1'b1;
      end
   end

endmodule

// File: rtl/bm_output_arbiter.sv
// bm_output_arbiter: shares one output bus among NUM_SRC BondMachine output
// ports. Sources are granted round-robin, their word is captured and then
// presented downstream.
//
// Handshake (both sides): the producer holds valid high with stable data
// until the consumer asserts received; a word moves on the rising edge
// where valid and received are both high. Upstream, in_received is the
// combinational acknowledge (one-hot or zero); downstream, out_valid is
// driven from the state register and out_received is the acceptance.
//
// Optional macro BM_ARB_TIMEOUT_EN: adds TIMEOUT_CYCLES and the dropped
// output; a word not accepted within TIMEOUT_CYCLES SEND cycles is discarded.
module bm_output_arbiter
   import bm_arb_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int SRC_W      = $clog2(NUM_SRC)
`ifdef BM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
)(
   input  logic                          clock_signal,
   input  logic                          reset_signal,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_SRC-1:0]            in_valid,
   output logic [NUM_SRC-1:0]            in_received,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_valid,
   input  logic                          out_received,
   output logic [SRC_W-1:0]              out_src,
   output bm_arb_state_e                 state_dbg
`ifdef BM_ARB_TIMEOUT_EN
   ,
   output logic                          dropped
`endif
);

   bm_arb_state_e      state_q;
   bm_arb_state_e      state_d;
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   winner;
   logic [NUM_SRC-1:0] winner_onehot;
   logic               any_req;
   logic               can_grant;
   logic               grant;
   logic               timeout_hit;

   bm_rr_picker #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_picker (
      .req    (in_valid),
      .ptr    (rr_ptr),
      .any    (any_req),
      .winner (winner),
      .onehot (winner_onehot)
   );

   // A new word may be taken when idle, or when the current one leaves now.
   assign can_grant   = (state_q == IDLE) || ((state_q == SEND) && out_received);
   // Reset blocks the acknowledge so no source loses a word to a discarded capture.
   assign grant       = can_grant && any_req && !reset_signal;
   assign in_received = grant ? winner_onehot : '0;
   assign out_valid   = (state_q == SEND);
   assign state_dbg   = state_q;

`ifdef BM_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;

   // Stalled SEND cycles reaching the limit; acceptance in that cycle wins.
   assign timeout_hit = (state_q == SEND) && !out_received &&
                        (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Wait counter: cleared on every capture, counts stalled SEND cycles.
   always_ff @(posedge clock_signal) begin
      if (reset_signal) begin
         to_cnt  <= '0;
         dropped <= 1'b0;
      end else begin
         dropped <= timeout_hit;
         if (grant) begin
            to_cnt <= '0;
         end else if ((state_q == SEND) && !out_received && !timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state logic: SEND persists across back-to-back grants.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (out_received) begin
               state_d = grant ? SEND : IDLE;
            end else if (timeout_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, round-robin pointer and capture registers; out_data is never
   // cleared after acceptance so the bus keeps showing the last word.
   always_ff @(posedge clock_signal) begin
      if (reset_signal) begin
         state_q  <= IDLE;
         rr_ptr   <= '0;
         out_data <= '0;
         out_src  <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            out_data <= in_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            out_src  <= winner;
            rr_ptr   <= SRC_W'(rr_index_next(32'(winner), 32'(NUM_SRC)));
         end
      end
   end

endmodule

// File: tb/tb_bm_output_arbiter.sv
// tb_bm_output_arbiter: directed bench for bm_output_arbiter. Define
// BM_ARB_TIMEOUT_EN to build the arbiter with TIMEOUT_CYCLES=8 and run the
// timeout scenario as well.
module tb_bm_output_arbiter;
   import bm_arb_pkg::*;

   localparam int NS = 4;
   localparam int DW = 8;
   localparam int SW = 2;

   // ---------------- clock / reset ----------------
   logic clock_signal = 1'b0;
   logic reset_signal = 1'b1;
   always #5 clock_signal = ~clock_signal;

   logic [NS*DW-1:0] in_data  = '0;
   logic [NS-1:0]    in_valid = '0;
   logic [NS-1:0]    in_received;
   logic [DW-1:0]    out_data;
   logic             out_valid;
   logic             out_received = 1'b0;
   logic [SW-1:0]    out_src;
   bm_arb_state_e    state_dbg;
`ifdef BM_ARB_TIMEOUT_EN
   logic             dropped;
`endif

   bm_output_arbiter #(
      .NUM_SRC    (NS),
      .DATA_WIDTH (DW)
`ifdef BM_ARB_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (8)
`endif
   ) dut (
      .clock_signal (clock_signal),
      .reset_signal (reset_signal),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_received  (in_received),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_received (out_received),
      .out_src      (out_src),
      .state_dbg    (state_dbg)
`ifdef BM_ARB_TIMEOUT_EN
      ,
      .dropped      (dropped)
`endif
   );

   // ---------------- scoreboard state ----------------
   logic [DW-1:0]    src_q[NS][$];
   logic [SW+DW-1:0] exp_q[$];
   logic [NS-1:0]    ack_s = '0;
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- source agents ----------------
   always @(negedge clock_signal) ack_s = in_received;

   // Each source presents the head of its queue, dropping it once acknowledged.
   always @(posedge clock_signal) begin
      #1;
      for (int i = 0; i < NS; i++) begin
         if (ack_s[i] && src_q[i].size() > 0) begin
            void'(src_q[i].pop_front());
         end
         in_valid[i] = (src_q[i].size() > 0);
         in_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clock_signal) begin
      if (!reset_signal && out_valid === 1'b1 && out_received === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got src=%0d data=%0h, none expected", out_src, out_data);
         end else begin
            check("word", 32'({out_src, out_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      for (int i = 0; i < NS; i++) src_q[i].delete();
      @(posedge clock_signal); #1;
      reset_signal = 1'b1;
      out_received = 1'b0;
      repeat (2) @(posedge clock_signal);
      #1;
      reset_signal = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clock_signal); #1;
      reset_signal = 1'b1;
      @(negedge clock_signal);
      check("rst_no_ack", 32'(in_received), 32'h0);
      @(posedge clock_signal); #1;
      reset_signal = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int c = 0; c < max_cyc && exp_q.size() > 0; c++) @(negedge clock_signal);
      check("drain", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int hi;
      bit found;

      // Reset then idle.
      do_reset();
      check("rst_src", 32'(out_src), 32'h0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clock_signal);
         check("idle_valid", 32'(out_valid), 32'h0);
         check("idle_data", 32'(out_data), 32'h0);
         check("idle_ack", 32'(in_received), 32'h0);
      end

      // Single source 2.
      @(posedge clock_signal); #1;
      out_received = 1'b1;
      @(negedge clock_signal);
      src_q[2].push_back(8'hA5);
      exp_q.push_back({2'd2, 8'hA5});
      @(negedge clock_signal);
      check("single_ack", 32'(in_received), 32'b0100);
      check("single_valid_t", 32'(out_valid), 32'h0);
      @(negedge clock_signal);
      check("single_valid_t1", 32'(out_valid), 32'h1);
      check("single_data", 32'(out_data), 32'hA5);
      check("single_src", 32'(out_src), 32'h2);
      @(negedge clock_signal);
      check("single_idle", 32'(state_dbg), 32'(IDLE));
      check("single_valid_t2", 32'(out_valid), 32'h0);
      check("single_hold", 32'(out_data), 32'hA5);
      wait_drain(10);

      // Round robin with every source requesting: 0,1,2,3,0,1,2,3 back to back.
      do_reset();
      @(posedge clock_signal); #1;
      out_received = 1'b1;
      @(negedge clock_signal);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NS; i++) begin
            src_q[i].push_back(8'(8'h10 + i));
            exp_q.push_back({2'(i), 8'(8'h10 + i)});
         end
      end
      hi = 0;
      repeat (12) begin
         @(negedge clock_signal);
         if (out_valid) hi++;
      end
      check("rr_rate", 32'(hi), 32'd8);
      wait_drain(10);

      // Backpressure with sources 0 and 1 requesting.
      do_reset();
      @(negedge clock_signal);
      src_q[0].push_back(8'h40);
      src_q[1].push_back(8'h41);
      exp_q.push_back({2'd0, 8'h40});
      exp_q.push_back({2'd1, 8'h41});
      @(negedge clock_signal);
      check("bp_first_ack", 32'(in_received), 32'b0001);
      for (int c = 0; c < 20; c++) begin
         @(negedge clock_signal);
         check("bp_hold_data", 32'(out_data), 32'h40);
         check("bp_hold_valid", 32'(out_valid), 32'h1);
         check("bp_no_ack", 32'(in_received), 32'h0);
      end
      @(posedge clock_signal); #1;
      out_received = 1'b1;
      @(negedge clock_signal);
      check("bp_second_ack", 32'(in_received), 32'b0010);
      wait_drain(10);

      // Reset during SEND; pending source 3 served afterwards.
      do_reset();
      @(negedge clock_signal);
      src_q[2].push_back(8'h52);
      @(negedge clock_signal);
      check("mr_ack2", 32'(in_received), 32'b0100);
      @(negedge clock_signal);
      src_q[3].push_back(8'h53);
      exp_q.push_back({2'd3, 8'h53});
      @(negedge clock_signal);
      check("mr_pending", 32'(in_received), 32'h0);
      pulse_reset();
      @(negedge clock_signal);
      check("mr_valid_low", 32'(out_valid), 32'h0);
      check("mr_ack3", 32'(in_received), 32'b1000);
      @(negedge clock_signal);
      check("mr_src3", 32'(out_src), 32'h3);
      check("mr_valid", 32'(out_valid), 32'h1);
      @(posedge clock_signal); #1;
      out_received = 1'b1;
      wait_drain(10);

      // Reset clears the round-robin pointer: ptr was 3, now source 1 wins.
      do_reset();
      @(negedge clock_signal);
      src_q[2].push_back(8'h62);
      @(negedge clock_signal);
      check("rp_ack2", 32'(in_received), 32'b0100);
      @(negedge clock_signal);
      src_q[1].push_back(8'h61);
      src_q[3].push_back(8'h63);
      exp_q.push_back({2'd1, 8'h61});
      exp_q.push_back({2'd3, 8'h63});
      @(negedge clock_signal);
      check("rp_pending", 32'(in_received), 32'h0);
      pulse_reset();
      @(negedge clock_signal);
      check("rp_ptr_zero", 32'(in_received), 32'b0010);
      @(posedge clock_signal); #1;
      out_received = 1'b1;
      wait_drain(10);

`ifdef BM_ARB_TIMEOUT_EN
      // Timeout: word dropped after 8 stalled SEND cycles.
      do_reset();
      @(negedge clock_signal);
      src_q[0].push_back(8'h70);
      @(negedge clock_signal);
      check("to_ack", 32'(in_received), 32'b0001);
      found = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock_signal);
         if (dropped && !found) begin
            found = 1'b1;
            check("to_cycle", 32'(k), 32'd9);
            check("to_valid_low", 32'(out_valid), 32'h0);
         end
      end
      check("to_seen", 32'(found), 32'h1);
      @(negedge clock_signal);
      src_q[1].push_back(8'h71);
      exp_q.push_back({2'd1, 8'h71});
      @(posedge clock_signal); #1;
      out_received = 1'b1;
      wait_drain(10);
`else
      found = 1'b0;
      hi = int'(found);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
